// File: rtl/rom_stream_rd_if.sv
// Bundle of the control, ROM-side and stream-side signals of rom_stream_rd.
interface rom_stream_rd_if #(
    parameter int unsigned Word_Width = 32,
    parameter int unsigned Addr_Width = 8
);
    logic                  start_i;
    logic [Addr_Width-1:0] base_addr_i;
    logic [Addr_Width:0]   len_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  rom_cen_o;
    logic                  rom_oen_o;
    logic [Addr_Width-1:0] rom_addr_o;
    logic [Word_Width-1:0] rom_data_i;
    logic                  dat_val_o;
    logic                  dat_rdy_i;
    logic [Word_Width-1:0] dat_o;
    logic                  dat_last_o;

    // Controller side
    modport slave (
        input  start_i, base_addr_i, len_i, rom_data_i, dat_rdy_i,
        output busy_o, done_o, rom_cen_o, rom_oen_o, rom_addr_o,
               dat_val_o, dat_o, dat_last_o
    );

    // Requester / ROM / consumer side
    modport master (
        output start_i, base_addr_i, len_i, rom_data_i, dat_rdy_i,
        input  busy_o, done_o, rom_cen_o, rom_oen_o, rom_addr_o,
               dat_val_o, dat_o, dat_last_o
    );
endinterface

// File: rtl/rom_stream_rd.sv
// Burst read controller for a 1-cycle-latency single-port ROM, delivering the
// words as a valid/ready stream through a 2-entry skid FIFO.
module rom_stream_rd #(
    parameter int unsigned Word_Width = 32,
    parameter int unsigned Addr_Width = 8
) (
    input  logic           clk,
    input  logic           rst,
    rom_stream_rd_if.slave bus
);
    localparam int unsigned LenW = Addr_Width + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [Addr_Width-1:0] addr_q, addr_d;
    logic [LenW-1:0]       iss_rem_q, iss_rem_d;
    logic [LenW-1:0]       pop_rem_q, pop_rem_d;
    logic                  inflight_q, inflight_d;
    logic [Word_Width-1:0] mem_q [2];
    logic [Word_Width-1:0] mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;

    // Next-state, read issue and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        iss_rem_d  = iss_rem_q;
        pop_rem_d  = pop_rem_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        pop   = (count_q != 2'd0) && bus.dat_rdy_i;
        occ   = 3'(count_q) + 3'(inflight_q);
        // Issue only if the FIFO is guaranteed a free slot when the data returns
        issue = (state_q == READ) && (iss_rem_q != '0) && (occ < (3'd2 + 3'(pop)));
        inflight_d = issue;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    addr_d    = bus.base_addr_i;
                    iss_rem_d = bus.len_i;
                    pop_rem_d = bus.len_i;
                    state_d   = (bus.len_i == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue) begin
                    addr_d    = addr_q + Addr_Width'(1);
                    iss_rem_d = iss_rem_q - LenW'(1);
                    if (iss_rem_q == LenW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (pop_rem_q == LenW'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            pop_rem_d = pop_rem_q - LenW'(1);
            rd_ptr_d  = ~rd_ptr_q;
        end

        if (inflight_q) begin
            mem_d[wr_ptr_q] = bus.rom_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end

        case ({inflight_q, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State, counter and FIFO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            iss_rem_q  <= '0;
            pop_rem_q  <= '0;
            inflight_q <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            iss_rem_q  <= iss_rem_d;
            pop_rem_q  <= pop_rem_d;
            inflight_q <= inflight_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign bus.busy_o     = (state_q != IDLE);
    assign bus.done_o     = (state_q == DONE);
    assign bus.rom_cen_o  = ~issue;
    assign bus.rom_oen_o  = (state_q == IDLE);
    assign bus.rom_addr_o = addr_q;
    assign bus.dat_val_o  = (count_q != 2'd0);
    assign bus.dat_o      = mem_q[rd_ptr_q];
    assign bus.dat_last_o = (count_q != 2'd0) && (pop_rem_q == LenW'(1));
endmodule

// File: tb/tb_rom_stream_rd.sv
// Self-checking bench for rom_stream_rd: ROM model plus a word-order reference
// (expected word k of a burst is ROM[(base+k) mod depth]).
module tb_rom_stream_rd;
    localparam int unsigned WW    = 32;
    localparam int unsigned AW    = 8;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rom_stream_rd_if #(.Word_Width(WW), .Addr_Width(AW)) bus ();

    rom_stream_rd #(.Word_Width(WW), .Addr_Width(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port ROM with one cycle read latency
    logic [WW-1:0] rom_mem [DEPTH];
    logic [WW-1:0] rom_q = '0;
    always @(posedge clk) if (!bus.rom_cen_o) rom_q <= rom_mem[bus.rom_addr_o];
    assign bus.rom_data_i = rom_q;

    int checks = 0;
    int errors = 0;

    task automatic fill_rom(input bit ramp);
        for (int i = 0; i < int'(DEPTH); i++) rom_mem[i] = ramp ? WW'(i * 3) : $urandom;
    endtask

    // Runs one burst; rdy_mode 0=always ready, 1=1,0,0,1 pattern, 2=random.
    // poke re-pulses start_i mid-burst with different parameters.
    task automatic run_burst(input logic [AW-1:0] base, input int len,
                             input int rdy_mode, input bit poke, input string name);
        int issued = 0;
        int popped = 0;
        int k = 0;
        int first_val = -1;
        int done_k = -1;
        bit stalled = 0;
        logic [WW-1:0] held = '0;
        logic [AW-1:0] exp_addr;
        logic [WW-1:0] exp_w;
        bus.start_i     = 1'b1;
        bus.base_addr_i = base;
        bus.len_i       = LW'(len);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        while (done_k < 0 && k < 4 * len + 20) begin
            case (rdy_mode)
                0:       bus.dat_rdy_i = 1'b1;
                1:       bus.dat_rdy_i = (k % 4 == 0) || (k % 4 == 3);
                default: bus.dat_rdy_i = 1'($urandom_range(0, 1));
            endcase
            if (poke && k == 3) begin
                bus.start_i     = 1'b1;
                bus.base_addr_i = ~base;
                bus.len_i       = LW'(5);
            end else begin
                bus.start_i = 1'b0;
            end
            @(negedge clk);
            if (!bus.rom_cen_o) begin
                checks++;
                exp_addr = base + AW'(issued);
                if (issued >= len || bus.rom_addr_o !== exp_addr) begin
                    errors++;
                    $display("FAIL %s rom_addr read#%0d got %h want %h (len %0d)",
                             name, issued, bus.rom_addr_o, exp_addr, len);
                end
                issued++;
            end
            if (bus.dat_val_o) begin
                if (first_val < 0) first_val = k;
                checks++;
                exp_w = rom_mem[base + AW'(popped)];
                if (popped >= len || bus.dat_o !== exp_w ||
                    bus.dat_last_o !== (popped == len - 1)) begin
                    errors++;
                    $display("FAIL %s word#%0d got %h last %b want %h last %b",
                             name, popped, bus.dat_o, bus.dat_last_o, exp_w, popped == len - 1);
                end
                if (stalled) begin
                    checks++;
                    if (bus.dat_o !== held) begin
                        errors++;
                        $display("FAIL %s stall_hold got %h want %h", name, bus.dat_o, held);
                    end
                end
                held    = bus.dat_o;
                stalled = !bus.dat_rdy_i;
                if (bus.dat_rdy_i) popped++;
            end else begin
                stalled = 0;
            end
            checks++;
            if (issued - popped > 2) begin
                errors++;
                $display("FAIL %s outstanding got %0d want <=2", name, issued - popped);
            end
            if (bus.done_o) done_k = k;
            k++;
            @(posedge clk); #1;
        end
        bus.start_i = 1'b0;
        checks++;
        if (done_k < 0) begin
            errors++;
            $display("FAIL %s done_timeout got none want done_o within %0d cycles", name, k);
        end
        checks++;
        if (issued != len || popped != len) begin
            errors++;
            $display("FAIL %s counts got issued %0d popped %0d want %0d", name, issued, popped, len);
        end
        if (rdy_mode == 0) begin
            checks++;
            if (done_k != ((len == 0) ? 0 : len + 2)) begin
                errors++;
                $display("FAIL %s done_cycle got %0d want %0d", name, done_k, (len == 0) ? 0 : len + 2);
            end
            if (len > 0) begin
                checks++;
                if (first_val != 2) begin
                    errors++;
                    $display("FAIL %s first_valid_cycle got %0d want 2", name, first_val);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.rom_cen_o !== 1'b1 ||
            bus.dat_val_o !== 1'b0) begin
            errors++;
            $display("FAIL %s post_done got done %b busy %b cen %b val %b want 0 0 1 0",
                     name, bus.done_o, bus.busy_o, bus.rom_cen_o, bus.dat_val_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.rom_cen_o !== 1'b1 ||
            bus.rom_oen_o !== 1'b1 || bus.rom_addr_o !== '0) begin
            errors++;
            $display("FAIL %s ctrl got busy %b done %b cen %b oen %b addr %h want 0 0 1 1 00",
                     name, bus.busy_o, bus.done_o, bus.rom_cen_o, bus.rom_oen_o, bus.rom_addr_o);
        end
        checks++;
        if (bus.dat_val_o !== 1'b0 || bus.dat_last_o !== 1'b0 || bus.dat_o !== '0) begin
            errors++;
            $display("FAIL %s stream got val %b last %b dat %h want 0 0 0",
                     name, bus.dat_val_o, bus.dat_last_o, bus.dat_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("after_reset");
    endtask

    task automatic test_ramp();
        fill_rom(1'b1);
        run_burst(8'h10, 4, 0, 1'b0, "ramp");
    endtask

    task automatic test_wrap();
        run_burst(8'hFE, 4, 0, 1'b0, "wrap");
    endtask

    task automatic test_backpressure();
        fill_rom(1'b0);
        run_burst(AW'($urandom), 8, 1, 1'b0, "pattern_rdy");
    endtask

    task automatic test_len_zero();
        run_burst(AW'($urandom), 0, 0, 1'b0, "len_zero");
    endtask

    task automatic test_busy_start();
        run_burst(8'h40, 8, 0, 1'b1, "busy_start");
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            run_burst(AW'($urandom), int'($urandom_range(1, 20)), 2, 1'b0, "random");
        end
    endtask

    task automatic test_full_rom();
        run_burst(AW'($urandom), int'(DEPTH), 2, 1'b0, "full_rom");
    endtask

    task automatic test_back_to_back();
        run_burst(8'hF0, 3, 0, 1'b0, "b2b_a");
        run_burst(8'h00, 1, 0, 1'b0, "b2b_b");
        run_burst(8'h7F, 2, 2, 1'b0, "b2b_c");
    endtask

    task automatic test_mid_reset();
        int popped = 0;
        int k = 0;
        bus.start_i     = 1'b1;
        bus.base_addr_i = 8'h20;
        bus.len_i       = LW'(8);
        bus.dat_rdy_i   = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        while (popped < 3 && k < 20) begin
            @(negedge clk);
            if (bus.dat_val_o) popped++;
            k++;
            if (popped < 3) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (popped != 3) begin
            errors++;
            $display("FAIL mid_reset words_before_reset got %0d want 3", popped);
        end
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        check_reset_outputs("mid_reset_held");
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_burst(8'h90, 5, 0, 1'b0, "post_reset");
    endtask

    initial begin
        rst             = 1'b0;
        bus.start_i     = 1'b0;
        bus.base_addr_i = '0;
        bus.len_i       = '0;
        bus.dat_rdy_i   = 1'b0;
        fill_rom(1'b1);
        test_reset();
        test_ramp();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_busy_start();
        test_random();
        test_full_rom();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
